// File: rtl/ram_arbiter.sv
// Round-robin 2:1 arbiter onto one 32-bit RAM port. Zero-wait memory gives a 3-cycle request-to-ack latency, registered outputs.
// Requesters hold level requests until their one-cycle ack. RAM_ARBITER_TIMEOUT_EN adds an abort with a sticky timeoutErr.
module ram_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] ramAddress0,
    input  logic [ADDR_WIDTH-1:0] ramAddress1,
    input  logic [31:0]           ramOut0,
    input  logic [31:0]           ramOut1,
    input  logic                  readReq0,
    input  logic                  readReq1,
    input  logic                  writeReq0,
    input  logic                  writeReq1,
    output logic [31:0]           ramIn0,
    output logic [31:0]           ramIn1,
    output logic                  readAck0,
    output logic                  readAck1,
    output logic                  writeAck0,
    output logic                  writeAck1,
    output logic [ADDR_WIDTH-1:0] memAddress,
    output logic [31:0]           memOut,
    output logic                  memReadReq,
    output logic                  memWriteReq,
    input  logic [31:0]           memIn,
    input  logic                  memReadAck,
    input  logic                  memWriteAck,
    output logic                  grant,
    output logic                  busy,
    output logic                  timeoutErr
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} state_t;

    state_t                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  grant_q, grant_d;
    logic                  busy_q, busy_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_out_q, mem_out_d;
    logic                  mem_rd_q, mem_rd_d;
    logic                  mem_wr_q, mem_wr_d;
    logic [31:0]           ram_in0_q, ram_in0_d;
    logic [31:0]           ram_in1_q, ram_in1_d;
    logic [1:0]            rd_ack_q, rd_ack_d;
    logic [1:0]            wr_ack_q, wr_ack_d;

    logic        pend0, pend1, sel, done, tmo;
    logic [31:0] rsp_dat;

    assign pend0   = readReq0 | writeReq0;
    assign pend1   = readReq1 | writeReq1;
    // A contested cycle goes to whoever was not served last; a lone requester always wins.
    assign sel     = (pend0 && pend1) ? ~last_grant_q : pend1;
    assign done    = wr_q ? memWriteAck : memReadAck;
    assign rsp_dat = done ? memIn : 32'hDEAD_BEEF;

`ifdef RAM_ARBITER_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] tmo_cnt_q;
    logic          tmo_err_q;

    assign tmo        = (state_q == WAIT) && (tmo_cnt_q == CW'(TIMEOUT - 1));
    assign timeoutErr = tmo_err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= (state_q == WAIT) ? tmo_cnt_q + 1'b1 : '0;
            if (tmo && !done) begin
                tmo_err_q <= 1'b1;
            end
        end
    end
`else
    assign tmo        = 1'b0;
    assign timeoutErr = 1'b0;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end
`endif

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        wr_d         = wr_q;
        mem_addr_d   = mem_addr_q;
        mem_out_d    = mem_out_q;
        mem_rd_d     = mem_rd_q;
        mem_wr_d     = mem_wr_q;
        ram_in0_d    = ram_in0_q;
        ram_in1_d    = ram_in1_q;
        rd_ack_d     = 2'b00;
        wr_ack_d     = 2'b00;

        case (state_q)
            IDLE: begin
                if (pend0 || pend1) begin
                    state_d      = ISSUE;
                    grant_d      = sel;
                    last_grant_d = sel;
                    wr_d         = sel ? writeReq1 : writeReq0;
                    mem_addr_d   = sel ? ramAddress1 : ramAddress0;
                    mem_out_d    = sel ? ramOut1 : ramOut0;
                    // Memory request is registered on entry so it is visible during ISSUE.
                    mem_rd_d     = ~wr_d;
                    mem_wr_d     = wr_d;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (done || tmo) begin
                    state_d  = RELEASE;
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                    if (wr_q) begin
                        wr_ack_d[grant_q] = 1'b1;
                    end else begin
                        rd_ack_d[grant_q] = 1'b1;
                        if (grant_q) begin
                            ram_in1_d = rsp_dat;
                        end else begin
                            ram_in0_d = rsp_dat;
                        end
                    end
                end
            end
            RELEASE: begin
                if (!memReadAck && !memWriteAck) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            busy_q       <= 1'b0;
            wr_q         <= 1'b0;
            mem_addr_q   <= '0;
            mem_out_q    <= '0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            ram_in0_q    <= '0;
            ram_in1_q    <= '0;
            rd_ack_q     <= 2'b00;
            wr_ack_q     <= 2'b00;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            busy_q       <= busy_d;
            wr_q         <= wr_d;
            mem_addr_q   <= mem_addr_d;
            mem_out_q    <= mem_out_d;
            mem_rd_q     <= mem_rd_d;
            mem_wr_q     <= mem_wr_d;
            ram_in0_q    <= ram_in0_d;
            ram_in1_q    <= ram_in1_d;
            rd_ack_q     <= rd_ack_d;
            wr_ack_q     <= wr_ack_d;
        end
    end

    assign grant       = grant_q;
    assign busy        = busy_q;
    assign memAddress  = mem_addr_q;
    assign memOut      = mem_out_q;
    assign memReadReq  = mem_rd_q;
    assign memWriteReq = mem_wr_q;
    assign ramIn0      = ram_in0_q;
    assign ramIn1      = ram_in1_q;
    assign readAck0    = rd_ack_q[0];
    assign readAck1    = rd_ack_q[1];
    assign writeAck0   = wr_ack_q[0];
    assign writeAck1   = wr_ack_q[1];

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, width of RAM address on all ports.
REQ-002 Parameter TIMEOUT, default 64, cycles of memory non-response before abort (REQ-024).
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 ramAddress0/ramAddress1  input  ADDR_WIDTH  requester 0/1 address, stable while request high.
REQ-006 ramOut0/ramOut1  input  32  requester 0/1 write data.
REQ-007 readReq0/readReq1, writeReq0/writeReq1  input  1  requester 0/1 level read/write requests.
REQ-008 ramIn0/ramIn1  output  32  read data to requester 0/1, valid with readAck.
REQ-009 readAck0/readAck1, writeAck0/writeAck1  output  1  one-cycle completion pulses to requester 0/1.
REQ-010 memAddress  output  ADDR_WIDTH; memOut  output  32; memReadReq, memWriteReq  output  1  memory-side request.
REQ-011 memIn  input  32; memReadAck, memWriteAck  input  1  memory-side response.
REQ-012 grant  output  1  index of requester owning memory; busy  output  1  high in any state other than IDLE.
REQ-013 timeoutErr  output  1  sticky memory-timeout flag.

Function
REQ-014 FSM states IDLE, ISSUE, WAIT, RELEASE; all outputs registered.
REQ-015 IDLE: on posedge with any request pending, select requester, latch its address/data/direction, go ISSUE; else stay.
REQ-016 Arbitration round-robin: both pending -> grant requester not granted last; one pending -> grant it; lastGrant resets to 1 (port 0 wins first contest).
REQ-017 A requester with both readReq and writeReq high is serviced as write only; only writeAck pulses.
REQ-018 ISSUE: drive memAddress, memOut, memReadReq or memWriteReq from latched values; go WAIT.
REQ-019 WAIT: hold memory request; when matching memReadAck/memWriteAck sampled high, drop memory request, drive ramInN = memIn (read only), pulse matching ack to granted requester for exactly one cycle, go RELEASE.
REQ-020 Minimum latency, zero-wait memory: request high in cycle 0, memory request cycle 1, ack pulse cycle 3 (one cycle per ISSUE, WAIT).
REQ-021 RELEASE: leave after at least one cycle and once memReadAck and memWriteAck are both low; go IDLE; request levels sampled during the ack cycle never cause a grant.
REQ-022 ramInN holds last read data until next read completion to that port; non-granted port ack outputs stay 0.
REQ-023 Requester dropping its request mid-transaction does not abort it; ack still pulses.

Reset
REQ-025 reset low asynchronously forces IDLE, lastGrant=1, grant=0, busy=0, all ack outputs 0, memReadReq=memWriteReq=0, memAddress=0, memOut=0, ramIn0=ramIn1=0, timeoutErr=0, timeout counter 0.
REQ-026 Reset mid-transaction abandons it with no ack pulse; first grant after reset release follows REQ-016.

Configuration
REQ-024 Macro RAM_ARBITER_TIMEOUT_EN defined: counter runs in WAIT; if no memory ack after TIMEOUT cycles, drop memory request, pulse requester ack with ramInN=32'hDEADBEEF for reads, set timeoutErr (held until reset), go RELEASE.
REQ-027 RAM_ARBITER_TIMEOUT_EN undefined: no counter; WAIT holds indefinitely; timeoutErr tied 0.

Verification
REQ-028 Reset release, readReq0=1 addr 8'h10, memory acks immediately with 32'h12345678 -> memReadReq cycle 1, readAck0 one-cycle pulse cycle 3, ramIn0=32'h12345678.
REQ-029 readReq0 and writeReq1 raised same cycle, repeated 4 times -> grants alternate 0,1,0,1; each gets exactly one ack per transaction.
REQ-030 Requester re-raises readReq the cycle after dropping it on ack (back-to-back) -> exactly one ack per request, no duplicate memory access.
REQ-031 memWriteAck held high 5 cycles after completion -> arbiter stays in RELEASE until it falls, no new memory request meanwhile.
REQ-032 Macro defined, TIMEOUT=64, memory never acks -> readAck0 pulses 64 cycles into WAIT with 32'hDEADBEEF, timeoutErr=1 until reset; macro undefined -> busy stays 1, no ack.
REQ-033 reset asserted while in WAIT -> all outputs reach reset values same cycle, no ack pulse after release.
